read_burst_issue: RTL and testbench

- Per-frame AXI4 read-address generator for the VDMA read path.
- Sits directly downstream of read_line_len_sum and consumes its tail_status/tail_len.
- On each fsync it issues full NOR_BURST_LEN bursts, then one tail burst of tail_len beats, incrementing the address from a frame base.
- It pulses burst_req/tail_req back to the length summer and issues a burst only when the downstream read-data FIFO reports enough free space.

---
 rtl/read_burst_issue_if.sv | 29 ++
 rtl/read_burst_issue.sv | 211 +++++++++++++++++++++
 tb/tb_read_burst_issue.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/read_burst_issue_if.sv
// AXI4 read-address channel bundle between the burst issuer and the AXI fabric.
interface read_burst_issue_if #(
    parameter int ASIZE = 32
);
    logic [ASIZE-1:0] axi_araddr;
    logic [7:0]       axi_arlen;
    logic [2:0]       axi_arsize;
    logic [1:0]       axi_arburst;
    logic             axi_arvalid;
    logic             axi_arready;

    modport master (
        output axi_araddr,
        output axi_arlen,
        output axi_arsize,
        output axi_arburst,
        output axi_arvalid,
        input  axi_arready
    );

    modport slave (
        input  axi_araddr,
        input  axi_arlen,
        input  axi_arsize,
        input  axi_arburst,
        input  axi_arvalid,
        output axi_arready
    );
endinterface

// File: rtl/read_burst_issue.sv
// Per-frame AXI4 read-address generator: full bursts, then one tail burst,
// gated by read-data FIFO space and paced by the length summer's status.
module read_burst_issue #(
    parameter int NOR_BURST_LEN = 128,
    parameter int AXI_DSIZE     = 256,
    parameter int ASIZE         = 32,
    parameter int LSIZE         = 9,
    parameter int FSIZE         = 10,
    parameter int STATUS_LAT    = 3
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic             fsync,
    input  logic [ASIZE-1:0] base_addr,
    input  logic             tail_status,
    input  logic [LSIZE-1:0] tail_len,
    input  logic [FSIZE-1:0] fifo_space,
    output logic             burst_req,
    output logic             tail_req,
    output logic             busy,
    output logic             frame_done,
    read_burst_issue_if.master ar
);
    localparam int unsigned BYTES = AXI_DSIZE / 8;
    localparam int          CW    = $clog2(STATUS_LAT + 2);

    typedef enum logic [2:0] {IDLE, SETTLE, CHECK, AR_NOR, AR_TAIL, DONE} state_t;

    state_t           state_q, state_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic [ASIZE-1:0] pend_addr_q, pend_addr_d;
    logic             pend_q, pend_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             arvalid_q, arvalid_d;
    logic [ASIZE-1:0] araddr_q, araddr_d;
    logic [7:0]       arlen_q, arlen_d;
    logic [8:0]       beats_q, beats_d;
    logic             burst_req_q, burst_req_d;
    logic             tail_req_q, tail_req_d;
    logic             frame_done_q, frame_done_d;

    logic             accept;
    logic             handshake;
    logic [8:0]       tail_beats;
    logic [31:0]      space32;

    assign accept    = fsync & enable;
    assign handshake = arvalid_q & ar.axi_arready;
    assign space32   = 32'(fifo_space);

    // Clamp the tail length to the largest legal AXI4 INCR burst.
    always_comb begin
        if (32'(tail_len) > 32'd256) tail_beats = 9'd256;
        else                         tail_beats = 9'(tail_len);
    end

    // State and datapath registers; asynchronous reset clears everything.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            pend_addr_q  <= '0;
            pend_q       <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            beats_q      <= '0;
            burst_req_q  <= 1'b0;
            tail_req_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pend_addr_q  <= pend_addr_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            beats_q      <= beats_d;
            burst_req_q  <= burst_req_d;
            tail_req_q   <= tail_req_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic: settle, check status/space, issue AR, handle restarts.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pend_addr_d  = pend_addr_q;
        pend_d       = pend_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        beats_d      = beats_q;
        burst_req_d  = 1'b0;
        tail_req_d   = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (accept) begin
                    addr_d  = base_addr;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(STATUS_LAT);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (accept) begin
                    addr_d = base_addr;
                    cnt_d  = CW'(STATUS_LAT);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_d == '0) state_d = CHECK;
                end
            end
            CHECK: begin
                if (accept) begin
                    addr_d  = base_addr;
                    cnt_d   = CW'(STATUS_LAT);
                    state_d = SETTLE;
                end else if (!tail_status) begin
                    if (space32 >= 32'(NOR_BURST_LEN)) begin
                        araddr_d  = addr_q;
                        arlen_d   = 8'(NOR_BURST_LEN - 1);
                        beats_d   = 9'(NOR_BURST_LEN);
                        arvalid_d = 1'b1;
                        state_d   = AR_NOR;
                    end
                end else if (tail_beats == '0) begin
                    tail_req_d = 1'b1;
                    state_d    = DONE;
                end else if (space32 >= 32'(tail_beats)) begin
                    araddr_d  = addr_q;
                    arlen_d   = 8'(tail_beats - 9'd1);
                    beats_d   = tail_beats;
                    arvalid_d = 1'b1;
                    state_d   = AR_TAIL;
                end
            end
            AR_NOR, AR_TAIL: begin
                if (handshake) begin
                    arvalid_d = 1'b0;
                    if (accept || pend_q) begin
                        // A frame restart requested while AR was outstanding
                        // takes effect only now; the burst is not reported.
                        addr_d  = accept ? base_addr : pend_addr_q;
                        pend_d  = 1'b0;
                        cnt_d   = CW'(STATUS_LAT);
                        state_d = SETTLE;
                    end else begin
                        addr_d = addr_q + ASIZE'(32'(beats_q) * BYTES);
                        if (state_q == AR_NOR) begin
                            burst_req_d = 1'b1;
                            // burst_req reaches the summer a cycle after the
                            // handshake, so its settle window starts one later.
                            cnt_d       = CW'(STATUS_LAT + 1);
                            state_d     = SETTLE;
                        end else begin
                            tail_req_d = 1'b1;
                            state_d    = DONE;
                        end
                    end
                end else if (accept) begin
                    pend_d      = 1'b1;
                    pend_addr_d = base_addr;
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
                if (accept) begin
                    addr_d  = base_addr;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(STATUS_LAT);
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef SYNTHESIS
    // Tail lengths above 256 indicate a summer/issuer configuration mismatch.
    always_ff @(posedge clock) begin
        if (!rst && state_q == CHECK && tail_status && 32'(tail_len) > 32'd256)
            $warning("read_burst_issue: tail_len %0d exceeds 256, clamped", tail_len);
    end
`endif

    assign burst_req      = burst_req_q;
    assign tail_req       = tail_req_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign ar.axi_araddr  = araddr_q;
    assign ar.axi_arlen   = arlen_q;
    assign ar.axi_arsize  = 3'($clog2(BYTES));
    assign ar.axi_arburst = 2'b01;
    assign ar.axi_arvalid = arvalid_q;
endmodule

// File: tb/tb_read_burst_issue.sv
// Bench for read_burst_issue with a behavioural length-summer model and an
// AR scoreboard of expected (address, length) pairs.
module tb_read_burst_issue;
    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        fsync = 1'b0;
    logic [31:0] base_addr = '0;
    logic        tail_status;
    logic [8:0]  tail_len;
    logic [9:0]  fifo_space = 10'd512;
    logic        burst_req, tail_req, busy, frame_done;

    int n_checks = 0;
    int n_pass = 0;
    int frame_len = 0;
    int rem;
    int n_breq = 0, n_treq = 0, n_done = 0;
    logic [39:0] exp_q[$];
    logic [39:0] obs_q[$];

    read_burst_issue_if #(.ASIZE(32)) ar_if ();

    read_burst_issue #(
        .NOR_BURST_LEN(128), .AXI_DSIZE(256), .ASIZE(32),
        .LSIZE(9), .FSIZE(10), .STATUS_LAT(3)
    ) dut (
        .clock(clock), .rst(rst), .enable(enable), .fsync(fsync),
        .base_addr(base_addr), .tail_status(tail_status), .tail_len(tail_len),
        .fifo_space(fifo_space), .burst_req(burst_req), .tail_req(tail_req),
        .busy(busy), .frame_done(frame_done), .ar(ar_if)
    );

    always #5 clock = ~clock;

    // Length-summer model: remaining beats, reloaded on fsync, minus 128 per burst_req.
    always @(posedge clock or posedge rst) begin
        if (rst) rem <= 0;
        else if (fsync) rem <= frame_len;
        else if (burst_req) rem <= rem - 128;
    end
    assign tail_status = (rem < 128);
    assign tail_len    = (rem < 128) ? 9'(rem) : 9'd0;

    // Observe AR handshakes and pulses on the falling edge.
    always @(negedge clock) begin
        if (!rst) begin
            if (ar_if.axi_arvalid && ar_if.axi_arready)
                obs_q.push_back({ar_if.axi_araddr, ar_if.axi_arlen});
            if (burst_req)  n_breq++;
            if (tail_req)   n_treq++;
            if (frame_done) n_done++;
        end
    end

    task automatic pulse_fsync(input logic [31:0] base, input int beats);
        @(negedge clock);
        base_addr = base;
        frame_len = beats;
        fsync = 1'b1;
        @(negedge clock);
        fsync = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int nobs, output logic busy_at);
        ok = 1'b0; nobs = -1; busy_at = 1'bx;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (frame_done) begin
                ok = 1'b1; nobs = obs_q.size(); busy_at = busy;
                break;
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++; if (ar_if.axi_arvalid !== 1'b0) $display("FAIL reset_arvalid: got %b expected 0", ar_if.axi_arvalid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if ({burst_req, tail_req, frame_done} !== 3'b000) $display("FAIL reset_pulses: got %b expected 000", {burst_req, tail_req, frame_done}); else n_pass++;
        n_checks++; if ({ar_if.axi_araddr, ar_if.axi_arlen} !== 40'h0) $display("FAIL reset_addr_len: got %h expected 0", {ar_if.axi_araddr, ar_if.axi_arlen}); else n_pass++;
        n_checks++; if (ar_if.axi_arsize !== 3'd5) $display("FAIL arsize: got %0d expected 5", ar_if.axi_arsize); else n_pass++;
        n_checks++; if (ar_if.axi_arburst !== 2'b01) $display("FAIL arburst: got %b expected 01", ar_if.axi_arburst); else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_frame_300();
        int lat, nobs, b0, t0, d0;
        bit ok;
        logic busy_at;
        logic [39:0] e, o;
        ar_if.axi_arready = 1'b1;
        fifo_space = 10'd512;
        b0 = n_breq; t0 = n_treq; d0 = n_done;
        exp_q.push_back({32'h1000_0000, 8'd127});
        exp_q.push_back({32'h1000_1000, 8'd127});
        exp_q.push_back({32'h1000_2000, 8'd43});
        @(negedge clock);
        base_addr = 32'h1000_0000; frame_len = 300; fsync = 1'b1;
        @(negedge clock);
        fsync = 1'b0;
        lat = 1;
        while (!ar_if.axi_arvalid && lat < 100) begin @(negedge clock); lat++; end
        n_checks++; if (lat !== 5) $display("FAIL first_ar_latency: got %0d expected 5", lat); else n_pass++;
        wait_done(200, ok, nobs, busy_at);
        n_checks++; if (ok !== 1'b1) $display("FAIL f300_done_timeout: got %b expected 1", ok); else n_pass++;
        n_checks++; if (nobs !== 3) $display("FAIL f300_ars_at_done: got %0d expected 3", nobs); else n_pass++;
        n_checks++; if (busy_at !== 1'b0) $display("FAIL f300_busy_at_done: got %b expected 0", busy_at); else n_pass++;
        n_checks++; if (n_breq - b0 !== 2) $display("FAIL f300_burst_req: got %0d expected 2", n_breq - b0); else n_pass++;
        n_checks++; if (n_treq - t0 !== 1) $display("FAIL f300_tail_req: got %0d expected 1", n_treq - t0); else n_pass++;
        n_checks++; if (n_done - d0 !== 1) $display("FAIL f300_frame_done: got %0d expected 1", n_done - d0); else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL f300_ar: got none expected addr %h len %0d", e[39:8], e[7:0]);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL f300_ar: got addr %h len %0d expected addr %h len %0d", o[39:8], o[7:0], e[39:8], e[7:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_exact_256();
        int nobs, b0, t0, d0;
        bit ok;
        logic busy_at;
        logic [39:0] e, o;
        b0 = n_breq; t0 = n_treq; d0 = n_done;
        exp_q.push_back({32'h2000_0000, 8'd127});
        exp_q.push_back({32'h2000_1000, 8'd127});
        pulse_fsync(32'h2000_0000, 256);
        wait_done(200, ok, nobs, busy_at);
        n_checks++; if (ok !== 1'b1) $display("FAIL f256_done_timeout: got %b expected 1", ok); else n_pass++;
        n_checks++; if (nobs !== 2) $display("FAIL f256_ars_at_done: got %0d expected 2", nobs); else n_pass++;
        n_checks++; if (n_breq - b0 !== 2) $display("FAIL f256_burst_req: got %0d expected 2", n_breq - b0); else n_pass++;
        n_checks++; if (n_treq - t0 !== 1) $display("FAIL f256_tail_req: got %0d expected 1", n_treq - t0); else n_pass++;
        n_checks++; if (n_done - d0 !== 1) $display("FAIL f256_frame_done: got %0d expected 1", n_done - d0); else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL f256_ar: got none expected addr %h len %0d", e[39:8], e[7:0]);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL f256_ar: got addr %h len %0d expected addr %h len %0d", o[39:8], o[7:0], e[39:8], e[7:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_fifo_stall();
        int nobs, arv, w;
        bit ok;
        logic busy_at;
        logic [39:0] e, o;
        fifo_space = 10'd100;
        exp_q.push_back({32'h3000_0000, 8'd127});
        exp_q.push_back({32'h3000_1000, 8'd127});
        exp_q.push_back({32'h3000_2000, 8'd43});
        pulse_fsync(32'h3000_0000, 300);
        arv = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (ar_if.axi_arvalid) arv++;
        end
        n_checks++; if (arv !== 0) $display("FAIL stall_no_arvalid: got %0d cycles expected 0", arv); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL stall_busy: got %b expected 1", busy); else n_pass++;
        fifo_space = 10'd200;
        w = 0;
        do begin @(negedge clock); w++; end while (!ar_if.axi_arvalid && w < 20);
        n_checks++; if (w !== 1) $display("FAIL stall_release_latency: got %0d expected 1", w); else n_pass++;
        wait_done(200, ok, nobs, busy_at);
        n_checks++; if (ok !== 1'b1) $display("FAIL stall_done_timeout: got %b expected 1", ok); else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL stall_ar: got none expected addr %h len %0d", e[39:8], e[7:0]);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL stall_ar: got addr %h len %0d expected addr %h len %0d", o[39:8], o[7:0], e[39:8], e[7:0]);
                else n_pass++;
            end
        end
        fifo_space = 10'd512;
    endtask

    task automatic test_arready_stall_restart();
        int nobs, w, unstable, b0, t0, d0;
        bit ok;
        logic busy_at;
        logic [31:0] a0;
        logic [7:0]  l0;
        logic [39:0] e, o;
        ar_if.axi_arready = 1'b0;
        exp_q.push_back({32'h4000_0000, 8'd127});
        pulse_fsync(32'h4000_0000, 300);
        w = 0;
        while (!ar_if.axi_arvalid && w < 50) begin @(negedge clock); w++; end
        n_checks++; if (ar_if.axi_arvalid !== 1'b1) $display("FAIL hold_arvalid_seen: got %b expected 1", ar_if.axi_arvalid); else n_pass++;
        a0 = ar_if.axi_araddr; l0 = ar_if.axi_arlen;
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 10) begin
                base_addr = 32'h5000_0000; frame_len = 300; fsync = 1'b1;
                exp_q.push_back({32'h5000_0000, 8'd127});
                exp_q.push_back({32'h5000_1000, 8'd127});
                exp_q.push_back({32'h5000_2000, 8'd43});
            end else fsync = 1'b0;
            if (!ar_if.axi_arvalid || ar_if.axi_araddr !== a0 || ar_if.axi_arlen !== l0) unstable++;
        end
        n_checks++; if (unstable !== 0) $display("FAIL hold_stable: got %0d unstable cycles expected 0", unstable); else n_pass++;
        b0 = n_breq; t0 = n_treq; d0 = n_done;
        ar_if.axi_arready = 1'b1;
        @(negedge clock);
        n_checks++; if ({burst_req, ar_if.axi_arvalid} !== 2'b00) $display("FAIL restart_no_burst_req: got %b expected 00", {burst_req, ar_if.axi_arvalid}); else n_pass++;
        wait_done(300, ok, nobs, busy_at);
        n_checks++; if (ok !== 1'b1) $display("FAIL restart_done_timeout: got %b expected 1", ok); else n_pass++;
        n_checks++; if (n_breq - b0 !== 2) $display("FAIL restart_burst_req: got %0d expected 2", n_breq - b0); else n_pass++;
        n_checks++; if (n_treq - t0 !== 1) $display("FAIL restart_tail_req: got %0d expected 1", n_treq - t0); else n_pass++;
        n_checks++; if (n_done - d0 !== 1) $display("FAIL restart_frame_done: got %0d expected 1", n_done - d0); else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL restart_ar: got none expected addr %h len %0d", e[39:8], e[7:0]);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL restart_ar: got addr %h len %0d expected addr %h len %0d", o[39:8], o[7:0], e[39:8], e[7:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midflight();
        int w, arv, bsy;
        ar_if.axi_arready = 1'b0;
        pulse_fsync(32'h6000_0000, 300);
        w = 0;
        while (!ar_if.axi_arvalid && w < 50) begin @(negedge clock); w++; end
        n_checks++; if (ar_if.axi_arvalid !== 1'b1) $display("FAIL rstmid_arvalid_before: got %b expected 1", ar_if.axi_arvalid); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({ar_if.axi_arvalid, busy} !== 2'b00) $display("FAIL rstmid_async_clear: got %b expected 00", {ar_if.axi_arvalid, busy}); else n_pass++;
        n_checks++; if ({burst_req, tail_req, frame_done} !== 3'b000) $display("FAIL rstmid_pulses: got %b expected 000", {burst_req, tail_req, frame_done}); else n_pass++;
        @(negedge clock);
        rst = 1'b0;
        ar_if.axi_arready = 1'b1;
        arv = 0; bsy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ar_if.axi_arvalid) arv++;
            if (busy) bsy++;
        end
        n_checks++; if (arv !== 0) $display("FAIL rstmid_idle_arvalid: got %0d expected 0", arv); else n_pass++;
        n_checks++; if (bsy !== 0) $display("FAIL rstmid_idle_busy: got %0d expected 0", bsy); else n_pass++;
        n_checks++; if (obs_q.size() !== 0) $display("FAIL rstmid_stray_ar: got %0d expected 0", obs_q.size()); else n_pass++;
    endtask

    task automatic test_enable_low();
        int arv, bsy;
        enable = 1'b0;
        pulse_fsync(32'h7000_0000, 300);
        arv = 0; bsy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ar_if.axi_arvalid) arv++;
            if (busy) bsy++;
        end
        n_checks++; if (arv !== 0) $display("FAIL en_low_arvalid: got %0d expected 0", arv); else n_pass++;
        n_checks++; if (bsy !== 0) $display("FAIL en_low_busy: got %0d expected 0", bsy); else n_pass++;
        enable = 1'b1;
    endtask

    initial begin
        ar_if.axi_arready = 1'b1;
        test_reset();
        test_frame_300();
        test_exact_256();
        test_fifo_stall();
        test_arready_stall_restart();
        test_reset_midflight();
        test_enable_low();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
